i2s_bram_capture: RTL

- Record-path counterpart of the BRAM sample player: takes 16-bit signed samples from the I2S receiver (already in the clk domain) and writes them into the shared BRAM as a clip.
- Small FIFO absorbs sample arrival; a write engine issues one 32-bit BRAM word per cycle.
- The PS reads the clip later over the other BRAM port.

---
 rtl/i2s_bram_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_bram_capture.sv
// i2s_bram_capture: records 16-bit I2S samples into BRAM as a clip, one 32-bit word per cycle.
// Optional build macro I2S_CAPTURE_CIRCULAR_EN: endless ring capture, done_irq on each wrap.
module i2s_bram_capture #(
  parameter int unsigned NUM_WORDS           = 256,
  parameter int unsigned FIFO_DEPTH          = 8,
  parameter int unsigned BASE_ADDR           = 0,
  parameter int unsigned BRAM_ADDR_INCREMENT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [31:0]                    BRAM_addr,
  output logic                           BRAM_clk,
  output logic [31:0]                    BRAM_din,
  input  logic [31:0]                    BRAM_dout,
  output logic                           BRAM_en,
  output logic                           BRAM_rst,
  output logic [3:0]                     BRAM_we,
  input  logic                           arm,
  input  logic                           abort,
  input  logic                           sample_valid,
  input  logic [15:0]                    sample_data,
  output logic                           busy,
  output logic                           done,
  output logic                           done_irq,
  output logic                           overflow,
  output logic [$clog2(NUM_WORDS+1)-1:0] words_written
);

  localparam int unsigned WW = $clog2(NUM_WORDS + 1);
  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WORDS - 1);
  localparam logic [WW-1:0] FULL_WORDS = WW'(NUM_WORDS);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

`ifdef I2S_CAPTURE_CIRCULAR_EN
  localparam bit CIRC_EN = 1'b1;
`else
  localparam bit CIRC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   acc_q, acc_d, ww_q, ww_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     addr_q, addr_d, din_q, din_d;
  logic            en_q, en_d, bram_rst_q;
  logic            busy_q, busy_d, done_q, done_d, irq_q, irq_d, ovf_q, ovf_d;
  logic            in_cap, pop_c, push_c, space, acc_ok;
  logic [15:0]     head;

  // Held low in normal operation; lets a bench stall the write engine to fill the FIFO.
  logic pop_stall;
  assign pop_stall = 1'b0;

  logic unused_dout;
  assign unused_dout = ^BRAM_dout;

  assign BRAM_clk      = clk;
  assign BRAM_addr     = addr_q;
  assign BRAM_din      = din_q;
  assign BRAM_en       = en_q;
  assign BRAM_we       = {4{en_q}};
  assign BRAM_rst      = bram_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_irq      = irq_q;
  assign overflow      = ovf_q;
  assign words_written = ww_q;
  assign head          = mem_q[rd_ptr_q];

  // Sample FIFO storage; pointers and count live in the main register block.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= sample_data;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ww_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      en_q       <= 1'b0;
      bram_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ww_q       <= ww_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      en_q       <= en_d;
      bram_rst_q <= 1'b0;
      busy_q     <= busy_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state, FIFO push/pop and write-strobe generation.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ww_d     = ww_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    din_d    = din_q;
    en_d     = 1'b0;
    ovf_d    = ovf_q;
    irq_d    = 1'b0;

    in_cap = (state_q == CAPTURE) && !abort;
    pop_c  = in_cap && (cnt_q != '0) && !pop_stall;
    space  = (cnt_q < DEPTH_C) || pop_c;
    acc_ok = CIRC_EN || (acc_q < FULL_WORDS);
    push_c = in_cap && sample_valid && acc_ok && space;

    case (state_q)
      IDLE, DONE: begin
        if (arm && !abort) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          acc_d    = '0;
          ww_d     = '0;
          idx_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          if (sample_valid && acc_ok && !space) ovf_d = 1'b1;
          if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (acc_q != FULL_WORDS) acc_d = acc_q + WW'(1);
          end
          if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            en_d     = 1'b1;
            addr_d   = 32'(BASE_ADDR) + 32'(BRAM_ADDR_INCREMENT) * 32'(idx_q);
            din_d    = {{16{head[15]}}, head};
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            if (ww_q != FULL_WORDS) ww_d = ww_q + WW'(1);
            if (CIRC_EN && (idx_q == LAST_IDX)) irq_d = 1'b1;
            if (!CIRC_EN && (ww_q == FULL_WORDS - WW'(1))) state_d = DONE;
          end
          if (push_c && !pop_c)      cnt_d = cnt_q + CW'(1);
          else if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE);
    done_d = (state_d == DONE);
    if ((state_d == DONE) && (state_q != DONE)) irq_d = 1'b1;
  end

endmodule
